// File: rtl/thiele_exec_observer.sv
// thiele_exec_observer
// Watches the Thiele CPU's PC, instruction and counter channels. Each observed
// cycle is folded into a rolling HASH_W-bit digest, and a saturating 64-bit
// mu-total is accumulated alongside it. A run ends either on the halt opcode,
// after a settle window, or when a programmable cycle timeout expires. One
// result record is then offered over a valid/ready handshake.
//
// Optional feature macro: OBS_STALL_DETECT_EN
//   When defined, a run also ends if the PC stays unchanged for STALL_LIMIT
//   cycles while in RUN (status 2'b11).
//   When undefined, there is no stall logic and status 2'b11 is never produced.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   start               begin a run (IDLE only)
//   timeout_limit       cycle budget, sampled on start (0 = no timeout)
//   obs_en              observation inputs valid this cycle
//   obs_pc, obs_instr   CPU PC and the instruction at that PC
//   obs_ch              NUM_CH counter words; channel k at [k*DATA_W +: DATA_W]
//   mu_inc              mu increment, added when obs_en is high
//   busy                high in RUN and SETTLE
//   result_valid/ready  result record handshake
//   result_status       00 none, 01 halt, 10 timeout, 11 stall
//   result_hash/mu/cycles/pc  final digest, mu-total, elapsed cycles, detect PC

module thiele_exec_observer #(
    parameter int          DATA_W        = 32,
    parameter int          NUM_CH        = 4,
    parameter int          HASH_W        = 256,
    parameter logic [7:0]  HALT_OPCODE   = 8'hFF,
    parameter int          SETTLE_CYCLES = 10,
    parameter int          TIMEOUT_W     = 24,
    parameter logic [31:0] SEED          = 32'hFACEB00C,
    parameter int          STALL_LIMIT   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [TIMEOUT_W-1:0]     timeout_limit,
    input  logic                     obs_en,
    input  logic [DATA_W-1:0]        obs_pc,
    input  logic [DATA_W-1:0]        obs_instr,
    input  logic [NUM_CH*DATA_W-1:0] obs_ch,
    input  logic [DATA_W-1:0]        mu_inc,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [1:0]               result_status,
    output logic [HASH_W-1:0]        result_hash,
    output logic [63:0]              result_mu,
    output logic [TIMEOUT_W-1:0]     result_cycles,
    output logic [DATA_W-1:0]        result_pc
);

    localparam int              LANES       = HASH_W / DATA_W;
    localparam int              NWORDS      = NUM_CH + 2;
    localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);
    localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE_CYCLES);

    generate
        if ((HASH_W % DATA_W) != 0 || NUM_CH < 1 || NUM_CH > 8 ||
            SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || STALL_LIMIT < 1) begin : g_bad_params
            $error("thiele_exec_observer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;

    logic [HASH_W-1:0]       r_lanes;
    logic [63:0]             r_mu;
    logic [TIMEOUT_W-1:0]    r_cycles;
    logic [TIMEOUT_W-1:0]    r_limit;
    logic [7:0]              r_settle;
    logic [DATA_W-1:0]       r_halt_pc;

    logic [1:0]              r_res_status;
    logic [HASH_W-1:0]       r_res_hash;
    logic [63:0]             r_res_mu;
    logic [TIMEOUT_W-1:0]    r_res_cycles;
    logic [DATA_W-1:0]       r_res_pc;

    logic [NWORDS*DATA_W-1:0] w_words;
    logic [DATA_W-1:0]       w_cyc_low;
    logic [HASH_W-1:0]       w_lanes_seed;
    logic [HASH_W-1:0]       w_lanes_abs;
    logic [HASH_W-1:0]       w_lanes_nxt;
    logic [64:0]             w_mu_sum;
    logic [63:0]             w_mu_nxt;
    logic [TIMEOUT_W-1:0]    w_cycles_inc;
    logic [TIMEOUT_W:0]      w_cycles_p1;
    logic                    w_halt_det;
    logic                    w_timeout_det;
    logic                    w_stall_det;
    logic                    w_finish;
    logic [1:0]              w_fin_status;
    logic [DATA_W-1:0]       w_fin_pc;

    // Word list W = {pc, instr, ch0..chN-1}, word 0 in the low bits.
    assign w_words   = {obs_ch, obs_instr, obs_pc};
    assign w_cyc_low = DATA_W'(r_cycles);

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            localparam int WI = g % NWORDS;
            assign w_lanes_seed[g*DATA_W +: DATA_W] = SEED_W ^ DATA_W'(g);
            assign w_lanes_abs[g*DATA_W +: DATA_W] =
                {r_lanes[g*DATA_W +: DATA_W-1], r_lanes[(g+1)*DATA_W-1]}
                ^ w_words[WI*DATA_W +: DATA_W]
                ^ w_cyc_low;
        end
    endgenerate

    assign w_lanes_nxt = obs_en ? w_lanes_abs : r_lanes;

    // One extra carry bit makes saturation a simple overflow test.
    assign w_mu_sum = {1'b0, r_mu} + {{(65-DATA_W){1'b0}}, mu_inc};
    assign w_mu_nxt = !obs_en     ? r_mu :
                      w_mu_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : w_mu_sum[63:0];

    assign w_cycles_inc  = (&r_cycles) ? r_cycles : r_cycles + TIMEOUT_W'(1);
    // Compare one bit wider so a saturated counter can never alias to a limit.
    assign w_cycles_p1   = {1'b0, r_cycles} + (TIMEOUT_W+1)'(1);
    assign w_halt_det    = obs_en && (obs_instr[DATA_W-1 -: 8] == HALT_OPCODE);
    assign w_timeout_det = (r_limit != '0) && (w_cycles_p1 == {1'b0, r_limit});

`ifdef OBS_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] r_stall;
    logic [STALL_W-1:0] w_stall_nxt;
    logic [DATA_W-1:0]  r_prev_pc;

    assign w_stall_nxt = (obs_en && (obs_pc != r_prev_pc)) ? '0 : r_stall + STALL_W'(1);
    assign w_stall_det = (w_stall_nxt == STALL_W'(STALL_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall   <= '0;
            r_prev_pc <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stall   <= '0;
            r_prev_pc <= '0;
        end else if (r_state == S_RUN) begin
            r_stall <= w_stall_nxt;
            if (obs_en) r_prev_pc <= obs_pc;
        end
    end
`else
    assign w_stall_det = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_finish     = 1'b0;
        w_fin_status = 2'b00;
        w_fin_pc     = obs_pc;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_halt_det) begin
                    w_state_nxt = S_SETTLE;
                end else if (w_timeout_det) begin
                    w_state_nxt  = S_DONE;
                    w_finish     = 1'b1;
                    w_fin_status = 2'b10;
                end else if (w_stall_det) begin
                    w_state_nxt  = S_DONE;
                    w_finish     = 1'b1;
                    w_fin_status = 2'b11;
                end
            end
            S_SETTLE: begin
                // Last settle cycle: counter is about to reach zero.
                if (r_settle == 8'd1) begin
                    w_state_nxt  = S_DONE;
                    w_finish     = 1'b1;
                    w_fin_status = 2'b01;
                    w_fin_pc     = r_halt_pc;
                end
            end
            S_DONE: begin
                if (result_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lanes      <= w_lanes_seed;
            r_mu         <= '0;
            r_cycles     <= '0;
            r_limit      <= '0;
            r_settle     <= '0;
            r_halt_pc    <= '0;
            r_res_status <= '0;
            r_res_hash   <= '0;
            r_res_mu     <= '0;
            r_res_cycles <= '0;
            r_res_pc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lanes  <= w_lanes_seed;
                        r_mu     <= '0;
                        r_cycles <= '0;
                        r_limit  <= timeout_limit;
                    end
                end
                S_RUN, S_SETTLE: begin
                    r_lanes  <= w_lanes_nxt;
                    r_mu     <= w_mu_nxt;
                    r_cycles <= w_cycles_inc;
                    if (r_state == S_RUN && w_halt_det) begin
                        r_halt_pc <= obs_pc;
                        r_settle  <= SETTLE_INIT;
                    end else if (r_state == S_SETTLE) begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                default: ;
            endcase

            // The finishing cycle is absorbed, so the record takes the next-state values.
            if (w_finish) begin
                r_res_status <= w_fin_status;
                r_res_hash   <= w_lanes_nxt;
                r_res_mu     <= w_mu_nxt;
                r_res_cycles <= w_cycles_inc;
                r_res_pc     <= w_fin_pc;
            end
        end
    end

    assign busy          = (r_state == S_RUN) || (r_state == S_SETTLE);
    assign result_valid  = (r_state == S_DONE);
    assign result_status = r_res_status;
    assign result_hash   = r_res_hash;
    assign result_mu     = r_res_mu;
    assign result_cycles = r_res_cycles;
    assign result_pc     = r_res_pc;

endmodule
